// File: rtl/ram_seq_master.sv
// ram_seq_master: sole initiator for one single-port synchronous-read RAM.
// Clears the RAM after reset, serves CPU req/ack accesses, streams burst reads.
// Ports:
//   clock, reset_n            clock, synchronous active-low reset
//   cpu_req/we/addr/wdata     CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata        one-cycle completion pulse, read data
//   scan_start/base/len       burst request (len 0 ignored)
//   scan_valid/data/busy      burst data stream and activity flag
//   clr_busy                  power-on clear in progress
//   ram_addr/clken/wren/data  RAM command outputs
//   ram_q                     RAM read data (one-cycle latency)
module ram_seq_master #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              scan_start,
    input  logic [ADDR_W-1:0] scan_base,
    input  logic [ADDR_W-1:0] scan_len,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_busy,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_clken,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [2:0] {
        CLEAR, IDLE, CPU_ACC, CPU_WAIT, SCAN
    } state_t;

    state_t state, state_n;

    logic              we_q;
    logic              rd_q;
    logic [ADDR_W-1:0] left;

    logic              n_we_q, n_rd_q;
    logic [ADDR_W-1:0] n_left, n_ram_addr;
    logic              n_cpu_ack, n_scan_valid;
    logic              n_scan_busy, n_clr_busy;
    logic              n_ram_clken, n_ram_wren;
    logic [DATA_W-1:0] n_cpu_rdata, n_scan_data;
    logic [DATA_W-1:0] n_ram_data;

    logic scan_go, cpu_go, last_clr, scan_done;

    assign scan_go  = scan_start && (scan_len != '0);
    // An ack still showing means the held request was just served.
    assign cpu_go   = cpu_req && !cpu_ack;
    assign last_clr = ram_clken && (ram_addr == '1);
    // The last word is on the output and no read is still in the RAM.
    assign scan_done = scan_valid && !rd_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= CLEAR;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            left        <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            scan_valid  <= 1'b0;
            scan_data   <= '0;
            scan_busy   <= 1'b0;
            clr_busy    <= 1'b1;
            ram_addr    <= '0;
            ram_clken   <= 1'b0;
            ram_wren    <= 1'b0;
            ram_data    <= '0;
        end else begin
            state       <= state_n;
            we_q        <= n_we_q;
            rd_q        <= n_rd_q;
            left        <= n_left;
            cpu_ack     <= n_cpu_ack;
            cpu_rdata   <= n_cpu_rdata;
            scan_valid  <= n_scan_valid;
            scan_data   <= n_scan_data;
            scan_busy   <= n_scan_busy;
            clr_busy    <= n_clr_busy;
            ram_addr    <= n_ram_addr;
            ram_clken   <= n_ram_clken;
            ram_wren    <= n_ram_wren;
            ram_data    <= n_ram_data;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            CLEAR:    if (last_clr) state_n = IDLE;
            IDLE: begin
                if (scan_go)     state_n = SCAN;
                else if (cpu_go) state_n = CPU_ACC;
            end
            CPU_ACC:  state_n = CPU_WAIT;
            CPU_WAIT: state_n = IDLE;
            SCAN:     if (scan_done) state_n = IDLE;
            default:  state_n = CLEAR;
        endcase
    end

    always_comb begin
        n_we_q       = we_q;
        n_rd_q       = 1'b0;
        n_left       = left;
        n_cpu_ack    = 1'b0;
        n_cpu_rdata  = cpu_rdata;
        n_scan_valid = 1'b0;
        n_scan_data  = scan_data;
        n_scan_busy  = scan_busy;
        n_clr_busy   = clr_busy;
        n_ram_addr   = ram_addr;
        n_ram_clken  = ram_clken;
        n_ram_wren   = ram_wren;
        n_ram_data   = ram_data;
        unique case (state)
            CLEAR: begin
                // clken low means the sweep has not started yet.
                if (!ram_clken) begin
                    n_ram_addr  = '0;
                    n_ram_clken = 1'b1;
                    n_ram_wren  = 1'b1;
                    n_ram_data  = '0;
                end else if (last_clr) begin
                    n_ram_clken = 1'b0;
                    n_ram_wren  = 1'b0;
                    n_clr_busy  = 1'b0;
                end else begin
                    n_ram_addr = ram_addr + 1'b1;
                end
            end
            IDLE: begin
                n_ram_clken = 1'b0;
                n_ram_wren  = 1'b0;
                if (scan_go) begin
                    n_scan_busy = 1'b1;
                    n_ram_addr  = scan_base;
                    n_ram_clken = 1'b1;
                    n_left      = scan_len - 1'b1;
                end else if (cpu_go) begin
                    n_ram_addr  = cpu_addr;
                    n_ram_clken = 1'b1;
                    n_ram_wren  = cpu_we;
                    n_ram_data  = cpu_wdata;
                    n_we_q      = cpu_we;
                end
            end
            CPU_ACC: begin
                n_ram_clken = 1'b0;
                n_ram_wren  = 1'b0;
            end
            CPU_WAIT: begin
                n_cpu_ack = 1'b1;
                if (!we_q) n_cpu_rdata = ram_q;
            end
            SCAN: begin
                // rd_q: a read was issued last cycle, q is valid now.
                n_rd_q       = ram_clken;
                n_scan_valid = rd_q;
                if (rd_q) n_scan_data = ram_q;
                if (ram_clken && left != '0) begin
                    n_ram_addr = ram_addr + 1'b1;
                    n_left     = left - 1'b1;
                end else begin
                    n_ram_clken = 1'b0;
                end
                if (scan_done) n_scan_busy = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
